// File: rtl/uart_rx_drain_ctrl.sv
// Drains the UART receive FIFO, screens bytes for pe/fe and packs them LE into 32-bit words.
// Latency: out_valid 2 cycles after the 4th read strobe; out_ready low holds the word and stalls reads.
module uart_rx_drain_ctrl #(
    parameter int unsigned TO_W     = 16,
    parameter bit          DROP_ERR = 1'b1
) (
    input  logic            pclk,
    input  logic            prst,
    input  logic            en,
    input  logic [TO_W-1:0] to_limit,
    input  logic            rx_rxne,
    input  logic [7:0]      rx_data,
    input  logic            rx_pe,
    input  logic            rx_fe,
    input  logic            rx_ov,
    input  logic            rx_busy,
    output logic            rx_rd,
    output logic [31:0]     out_data,
    output logic [2:0]      out_bytes,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            to_irq,
    output logic            err_flag,
    input  logic            err_clr
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_PUSH} state_t;

    localparam logic [TO_W-1:0] TO_ONE = {{(TO_W-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [7:0]      lat_data_q, lat_data_d;
    logic            lat_err_q, lat_err_d;
    logic [31:0]     pack_q, pack_d;
    logic [2:0]      byte_cnt_q, byte_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;
    logic            ov_q;
    logic            to_inc, to_fire;
    logic            rd_c, irq_c;

    // Idle-line timeout only runs while a partial word is waiting and the line is quiet.
    assign to_inc  = (state_q == S_IDLE) && (byte_cnt_q != 3'd0) && !rx_rxne && !rx_busy
                     && en && (to_limit != '0);
    assign to_fire = to_inc && (to_cnt_q == (to_limit - TO_ONE));

    always_comb begin
        state_d    = state_q;
        lat_data_d = lat_data_q;
        lat_err_d  = lat_err_q;
        pack_d     = pack_q;
        byte_cnt_d = byte_cnt_q;
        to_cnt_d   = to_cnt_q;
        err_d      = err_q;
        rd_c       = 1'b0;
        irq_c      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Gated by reset so the strobe is quiet while the block is held in reset.
                rd_c = en && rx_rxne && !prst;
                if (rd_c) begin
                    lat_data_d = rx_data;
                    lat_err_d  = rx_pe | rx_fe;
                    state_d    = S_READ;
                end else if (to_fire) begin
                    irq_c   = 1'b1;
                    state_d = S_PUSH;
                end
            end
            S_READ: begin
                state_d = S_IDLE;
                if (!lat_err_q || !DROP_ERR) begin
                    pack_d[{byte_cnt_q[1:0], 3'b000} +: 8] = lat_data_q;
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (byte_cnt_d == 3'd4) state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                if (out_ready) begin
                    pack_d     = '0;
                    byte_cnt_d = 3'd0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rd_c || rx_busy || (state_d == S_PUSH && state_q != S_PUSH)) begin
            to_cnt_d = '0;
        end else if (to_inc && (to_cnt_q != {TO_W{1'b1}})) begin
            to_cnt_d = to_cnt_q + TO_ONE;
        end

        if (err_clr) err_d = 1'b0;
        if (((state_q == S_READ) && lat_err_q) || (rx_ov && !ov_q)) err_d = 1'b1;
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state_q    <= S_IDLE;
            lat_data_q <= 8'd0;
            lat_err_q  <= 1'b0;
            pack_q     <= 32'd0;
            byte_cnt_q <= 3'd0;
            to_cnt_q   <= '0;
            err_q      <= 1'b0;
            ov_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_data_q <= lat_data_d;
            lat_err_q  <= lat_err_d;
            pack_q     <= pack_d;
            byte_cnt_q <= byte_cnt_d;
            to_cnt_q   <= to_cnt_d;
            err_q      <= err_d;
            ov_q       <= rx_ov;
        end
    end

    assign rx_rd     = rd_c;
    assign to_irq    = irq_c;
    assign out_valid = (state_q == S_PUSH);
    assign out_data  = pack_q;
    assign out_bytes = byte_cnt_q;
    assign err_flag  = err_q;

endmodule

// File: tb/tb_uart_rx_drain_ctrl.sv
// Bench for uart_rx_drain_ctrl: FIFO feeder model, word scoreboard, vector table and corner sequences.
module tb_uart_rx_drain_ctrl;

    logic        pclk = 1'b0;
    logic        prst;
    logic        en;
    logic [15:0] to_limit;
    logic        rx_rxne;
    logic [7:0]  rx_data;
    logic        rx_pe, rx_fe, rx_ov, rx_busy;
    logic        rx_rd;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;
    logic        out_valid;
    logic        out_ready;
    logic        to_irq;
    logic        err_flag;
    logic        err_clr;

    int checks = 0;
    int errors = 0;

    uart_rx_drain_ctrl #(.TO_W(16), .DROP_ERR(1'b1)) dut (
        .pclk(pclk), .prst(prst), .en(en), .to_limit(to_limit),
        .rx_rxne(rx_rxne), .rx_data(rx_data), .rx_pe(rx_pe), .rx_fe(rx_fe),
        .rx_ov(rx_ov), .rx_busy(rx_busy), .rx_rd(rx_rd),
        .out_data(out_data), .out_bytes(out_bytes), .out_valid(out_valid),
        .out_ready(out_ready), .to_irq(to_irq), .err_flag(err_flag), .err_clr(err_clr)
    );

    always #5 pclk = ~pclk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Receive FIFO model: entries are {pe, fe, data}; head advances after a strobe edge.
    logic [9:0]  fifo[$];
    logic [34:0] sb[$];
    logic        rd_seen = 1'b0;
    logic        prev_rd = 1'b0;

    initial begin
        rx_rxne = 1'b0; rx_data = 8'h5A; rx_pe = 1'b0; rx_fe = 1'b0;
        forever begin
            @(posedge pclk);
            #1;
            if (rd_seen && fifo.size() != 0) void'(fifo.pop_front());
            rx_rxne = (fifo.size() != 0);
            if (fifo.size() != 0) {rx_pe, rx_fe, rx_data} = fifo[0];
            else begin rx_pe = 1'b0; rx_fe = 1'b0; rx_data = 8'h5A; end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge pclk) begin
        rd_seen = rx_rd;
        if (!prst) begin
            if (rx_rd) chk("rd_spacing_prev", {31'd0, prev_rd}, 32'd0);
            prev_rd = rx_rd;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_word", out_data, 32'hFFFF_FFFF);
                else begin
                    logic [34:0] e;
                    e = sb.pop_front();
                    chk("word_data", out_data, e[34:3]);
                    chk("word_bytes", {29'd0, out_bytes}, {29'd0, e[2:0]});
                end
            end
        end else prev_rd = 1'b0;
    end

    task automatic tick();
        @(posedge pclk);
        #2;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic pe, input logic fe);
        fifo.push_back({pe, fe, d});
    endtask

    task automatic wait_sb(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge pclk);
            n++;
        end
        #2;
        chk("sb_drain_pending", sb.size(), 32'd0);
        sb.delete();
    endtask

    typedef struct {
        int          n;
        logic [39:0] b;
        logic [4:0]  bad;
        logic [15:0] to;
        logic [31:0] exp_d;
        logic [2:0]  exp_n;
        logic        exp_err;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int last_rd, irq_at, irq_cnt, cnt_rd, cnt_irq, cnt_vld, n;

        tbl[0] = '{4, 40'h0044332211, 5'b00000, 16'd0, 32'h44332211, 3'd4, 1'b0};
        tbl[1] = '{2, 40'h000000BBAA, 5'b00000, 16'd8, 32'h0000BBAA, 3'd2, 1'b0};
        tbl[2] = '{5, 40'h0403020155, 5'b00001, 16'd0, 32'h04030201, 3'd4, 1'b1};
        tbl[3] = '{1, 40'h000000007E, 5'b00000, 16'd3, 32'h0000007E, 3'd1, 1'b0};
        tbl[4] = '{3, 40'h0000BEADDE, 5'b00010, 16'd5, 32'h0000BEDE, 3'd2, 1'b1};
        tbl[5] = '{4, 40'h0000FF00FF, 5'b00000, 16'd0, 32'h00FF00FF, 3'd4, 1'b0};

        prst = 1'b1; en = 1'b0; to_limit = 16'd0; rx_ov = 1'b0; rx_busy = 1'b0;
        out_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("rst_rx_rd", {31'd0, rx_rd}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_to_irq", {31'd0, to_irq}, 32'd0);
        chk("rst_err_flag", {31'd0, err_flag}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_bytes", {29'd0, out_bytes}, 32'd0);
        tick();
        prst = 1'b0; en = 1'b1; out_ready = 1'b1;
        tick();

        // Vector table: bytes in, expected word and error flag out.
        for (int r = 0; r < 6; r++) begin
            to_limit = tbl[r].to;
            err_clr = 1'b1; tick(); err_clr = 1'b0;
            sb.push_back({tbl[r].exp_d, tbl[r].exp_n});
            for (int i = 0; i < tbl[r].n; i++)
                push_byte(tbl[r].b[8*i +: 8], tbl[r].bad[i] && (i % 2 == 0), tbl[r].bad[i] && (i % 2 == 1));
            wait_sb(200);
            repeat (3) tick();
            chk("tbl_err_flag", {31'd0, err_flag}, {31'd0, tbl[r].exp_err});
        end

        // Timeout timing: irq exactly in the 8th idle cycle after the READ of the last byte.
        to_limit = 16'd8;
        sb.push_back({32'h0000BBAA, 3'd2});
        push_byte(8'hAA, 1'b0, 1'b0); push_byte(8'hBB, 1'b0, 1'b0);
        last_rd = -100; irq_at = -1; irq_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge pclk);
            if (rx_rd) last_rd = i;
            if (to_irq) begin irq_cnt++; irq_at = i; end
        end
        chk("to_irq_count", irq_cnt, 32'd1);
        chk("to_irq_delay", irq_at - last_rd, 32'd9);
        wait_sb(20);

        // Dropped pe byte: no word, flag set; clear colliding with rx_ov rise keeps it set.
        to_limit = 16'd0;
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        push_byte(8'h55, 1'b1, 1'b0);
        cnt_vld = 0;
        for (int i = 0; i < 8; i++) begin @(negedge pclk); if (out_valid) cnt_vld++; end
        chk("drop_no_word", cnt_vld, 32'd0);
        chk("drop_err_set", {31'd0, err_flag}, 32'd1);
        tick();
        err_clr = 1'b1; rx_ov = 1'b1; tick();
        err_clr = 1'b0;
        @(negedge pclk);
        chk("clr_vs_ov_set_wins", {31'd0, err_flag}, 32'd1);
        tick();
        rx_ov = 1'b0; err_clr = 1'b1; tick(); err_clr = 1'b0;
        @(negedge pclk);
        chk("err_clr_alone", {31'd0, err_flag}, 32'd0);

        // Backpressure: word held, no reads, resume right after acceptance.
        tick();
        out_ready = 1'b0;
        sb.push_back({32'h04030201, 3'd4});
        sb.push_back({32'h08070605, 3'd4});
        for (int i = 1; i <= 8; i++) push_byte(i[7:0], 1'b0, 1'b0);
        last_rd = -100; n = 0;
        while (!out_valid && n < 40) begin
            @(negedge pclk);
            if (rx_rd) last_rd = n;
            n++;
        end
        chk("push_latency", (n - 1) - last_rd, 32'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            chk("bp_rx_rd", {31'd0, rx_rd}, 32'd0);
            chk("bp_out_data", out_data, 32'h04030201);
        end
        tick();
        out_ready = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        chk("resume_rd", {31'd0, rx_rd}, 32'd1);
        wait_sb(100);

        // en low holds a 3-byte partial word: no reads, no flush.
        tick();
        sb.push_back({32'h99563412, 3'd4});
        push_byte(8'h12, 1'b0, 1'b0); push_byte(8'h34, 1'b0, 1'b0); push_byte(8'h56, 1'b0, 1'b0);
        n = 0;
        while (fifo.size() != 0 && n < 50) begin tick(); n++; end
        repeat (2) tick();
        en = 1'b0; to_limit = 16'd4;
        push_byte(8'h99, 1'b0, 1'b0);
        cnt_rd = 0; cnt_irq = 0; cnt_vld = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            if (rx_rd) cnt_rd++;
            if (to_irq) cnt_irq++;
            if (out_valid) cnt_vld++;
        end
        chk("dis_rx_rd", cnt_rd, 32'd0);
        chk("dis_to_irq", cnt_irq, 32'd0);
        chk("dis_out_valid", cnt_vld, 32'd0);
        tick();
        en = 1'b1;
        wait_sb(50);

        // Async reset in PUSH drops the word; next bytes restart at lane 0.
        to_limit = 16'd0; out_ready = 1'b0;
        rx_ov = 1'b1; tick(); rx_ov = 1'b0; tick();
        for (int i = 0; i < 6; i++) push_byte(8'hC1 + i[7:0], 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 40) begin @(negedge pclk); n++; end
        chk("rst_push_reached", {31'd0, out_valid}, 32'd1);
        @(posedge pclk); #2;
        prst = 1'b1;
        #1;
        chk("rst_mid_rxne_hi", {31'd0, rx_rxne}, 32'd1);
        chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_rx_rd", {31'd0, rx_rd}, 32'd0);
        chk("rst_mid_to_irq", {31'd0, to_irq}, 32'd0);
        chk("rst_mid_err_flag", {31'd0, err_flag}, 32'd0);
        fifo.delete();
        repeat (2) tick();
        prst = 1'b0; out_ready = 1'b1;
        tick();
        sb.push_back({32'hA4A3A2A1, 3'd4});
        for (int i = 0; i < 4; i++) push_byte(8'hA1 + i[7:0], 1'b0, 1'b0);
        wait_sb(100);

        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
